song_reader: RTL and testbench

//  Sequencer directly upstream of note_player. Walks the song ROM for the selected

---
 rtl/song_pkg.sv | 54 +++++
 rtl/song_rom.sv | 18 +
 rtl/song_reader.sv | 96 +++++++++
 tb/tb_song_reader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// Shared widths, FSM state encoding and song ROM contents for the song sequencer.
package song_pkg;

    localparam int SONG_W = 2;
    localparam int IDX_W  = 5;
    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;

    localparam logic [DUR_W-1:0] END_MARKER_DUR = '0;
    localparam logic [IDX_W-1:0] IDX_LAST       = '1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_WAIT_ROM  = 3'd2;
    localparam logic [2:0] S_NEW_NOTE  = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_END       = 3'd5;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } rom_word_t;

    // Song table: a zero duration marks the end of a song.
    function automatic rom_word_t rom_word(input logic [SONG_W-1:0] song,
                                           input logic [IDX_W-1:0]  idx);
        rom_word_t w;
        w = '{note: '0, dur: END_MARKER_DUR};
        case (song)
            2'd0: begin
                case (idx)
                    5'd0:    w = '{note: 6'd20, dur: 6'd12};
                    5'd1:    w = '{note: 6'd22, dur: 6'd5};
                    5'd2:    w = '{note: 6'd25, dur: 6'd7};
                    default: ;
                endcase
            end
            2'd1: begin
                w.note = NOTE_W'(idx) + 6'd1;
                w.dur  = 6'd32 - DUR_W'(idx);
            end
            2'd2: begin
                case (idx)
                    5'd0:    w = '{note: 6'd30, dur: 6'd3};
                    5'd1:    w = '{note: 6'd31, dur: 6'd4};
                    default: ;
                endcase
            end
            default: ;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/song_rom.sv
// Synchronous-read song ROM; data appears one cycle after the address.
module song_rom
    import song_pkg::*;
(
    input  logic                    i_clk,
    input  logic [SONG_W+IDX_W-1:0] i_addr,
    output rom_word_t               o_data
);

    rom_word_t r_data;

    always_ff @(posedge i_clk) begin
        r_data <= rom_word(i_addr[SONG_W+IDX_W-1:IDX_W], i_addr[IDX_W-1:0]);
    end

    assign o_data = r_data;

endmodule

// File: rtl/song_reader.sv
// Walks the selected song in ROM and hands (note, duration) pairs to note_player,
// one per new_note strobe, waiting for each done_with_note rise before moving on.
module song_reader
    import song_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_play,
    input  logic [SONG_W-1:0] i_song,
    input  logic              i_note_done,
    output logic [NOTE_W-1:0] o_note,
    output logic [DUR_W-1:0]  o_duration,
    output logic              o_new_note,
    output logic              o_song_done
);

    logic [2:0]        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [SONG_W-1:0] r_song_q;
    logic              r_note_done_q;
    logic [NOTE_W-1:0] r_note;
    logic [DUR_W-1:0]  r_duration;

    rom_word_t w_rom;
    logic      w_song_chg;
    logic      w_done_rise;

    song_rom u_rom (
        .i_clk  (i_clk),
        .i_addr ({r_song_q, r_idx}),
        .o_data (w_rom)
    );

    // A change seen in END is only latched; everywhere else it restarts the song.
    assign w_song_chg  = (i_song != r_song_q) && (r_state != S_END);
    assign w_done_rise = i_note_done & ~r_note_done_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_song_q      <= '0;
            r_note_done_q <= 1'b0;
            r_note        <= '0;
            r_duration    <= '0;
        end else begin
            r_note_done_q <= i_note_done;
            if (w_song_chg) begin
                r_song_q <= i_song;
                r_idx    <= '0;
                r_state  <= S_FETCH;
            end else begin
                case (r_state)
                    S_IDLE: if (i_play) r_state <= S_FETCH;
                    S_FETCH: if (i_play) r_state <= S_WAIT_ROM;
                    S_WAIT_ROM: begin
                        if (i_play) begin
                            if (w_rom.dur == END_MARKER_DUR) begin
                                r_state <= S_END;
                            end else begin
                                r_note     <= w_rom.note;
                                r_duration <= w_rom.dur;
                                r_state    <= S_NEW_NOTE;
                            end
                        end
                    end
                    S_NEW_NOTE: if (i_play) r_state <= S_WAIT_DONE;
                    S_WAIT_DONE: begin
                        if (w_done_rise) begin
                            if (r_idx == IDX_LAST) begin
                                r_state <= S_END;
                            end else begin
                                r_idx   <= r_idx + IDX_W'(1);
                                r_state <= S_FETCH;
                            end
                        end
                    end
                    S_END: begin
                        r_idx    <= '0;
                        r_song_q <= i_song;
                        r_state  <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Strobe fires in the single cycle NEW_NOTE actually hands off, so a pause
    // there delays it rather than duplicating it.
    assign o_new_note  = (r_state == S_NEW_NOTE) && i_play && !w_song_chg;
    assign o_song_done = (r_state == S_END);
    assign o_note      = r_note;
    assign o_duration  = r_duration;

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: scoreboard of expected hand-offs plus directed timing checks.
module tb_song_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       play;
    logic [1:0] song;
    logic       note_done;
    logic [5:0] note;
    logic [5:0] duration;
    logic       new_note;
    logic       song_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         kind;   // 0 = new_note hand-off, 1 = song_done
        logic [5:0] note;
        logic [5:0] dur;
    } ev_t;
    ev_t sb[$];

    typedef struct {
        logic [1:0] song;
        logic [5:0] note;
        logic [5:0] dur;
    } vec_t;

    logic [5:0] exp_note[4][32];
    logic [5:0] exp_dur[4][32];
    int         exp_len[4];

    song_reader dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_play      (play),
        .i_song      (song),
        .i_note_done (note_done),
        .o_note      (note),
        .o_duration  (duration),
        .o_new_note  (new_note),
        .o_song_done (song_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (!rst && (new_note || song_done)) begin
            ev_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected: new_note=%0b song_done=%0b note=%0d dur=%0d, nothing expected",
                         new_note, song_done, note, duration);
            end else begin
                e = sb.pop_front();
                if (e.kind != song_done || (!e.kind && (note !== e.note || duration !== e.dur))) begin
                    errors++;
                    $display("FAIL scoreboard: got song_done=%0b note=%0d dur=%0d, expected kind=%0d note=%0d dur=%0d",
                             song_done, note, duration, e.kind, e.note, e.dur);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_note(input logic [1:0] s, input int i);
        sb.push_back('{1'b0, exp_note[s][i], exp_dur[s][i]});
    endtask

    task automatic push_done();
        sb.push_back('{1'b1, 6'd0, 6'd0});
    endtask

    // Waits (bounded) for new_note (sel=0) or song_done (sel=1) at a negedge.
    task automatic wait_ev(input bit sel, input string nm);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (sel ? song_done : new_note) break;
        end
        if (!(sel ? song_done : new_note)) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for %s, got 0 expected 1", nm, sel ? "song_done" : "new_note");
        end
    endtask

    // Stimulus was driven this cycle; the strobe must appear exactly 3 edges later.
    task automatic check_gap(input string nm, input bit sel);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("%s_k%0d", nm, k), {31'd0, sel ? song_done : new_note}, {31'd0, k == 3});
        end
    endtask

    task automatic done_pulse();
        @(posedge clk); #1 note_done = 1'b1;
        @(posedge clk); #1 note_done = 1'b0;
    endtask

    task automatic play_through(input logic [1:0] s, input bit keep);
        @(posedge clk); #1 song = s; play = 1'b1;
        for (int i = 0; i < exp_len[s]; i++) begin
            push_note(s, i);
            wait_ev(1'b0, $sformatf("song%0d_idx%0d", s, i));
            done_pulse();
        end
        push_done();
        if (keep) push_note(s, 0);
        wait_ev(1'b1, $sformatf("song%0d_done", s));
        if (keep) begin
            wait_ev(1'b0, $sformatf("song%0d_restart", s));
        end else begin
            @(posedge clk); #1 play = 1'b0;
        end
    endtask

    initial begin
        vec_t vecs[5];
        vecs = '{'{2'd0, 6'd20, 6'd12}, '{2'd0, 6'd22, 6'd5}, '{2'd0, 6'd25, 6'd7},
                 '{2'd2, 6'd30, 6'd3},  '{2'd2, 6'd31, 6'd4}};
        for (int s = 0; s < 4; s++) exp_len[s] = 0;
        foreach (vecs[v]) begin
            exp_note[vecs[v].song][exp_len[vecs[v].song]] = vecs[v].note;
            exp_dur[vecs[v].song][exp_len[vecs[v].song]]  = vecs[v].dur;
            exp_len[vecs[v].song]++;
        end
        for (int i = 0; i < 32; i++) begin
            exp_note[1][i] = 6'(i + 1);
            exp_dur[1][i]  = 6'(32 - i);
        end
        exp_len[1] = 32;

        rst = 1'b1; play = 1'b0; song = 2'd0; note_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_note", {26'd0, note}, 32'd0);
        chk("reset_duration", {26'd0, duration}, 32'd0);
        chk("reset_new_note", {31'd0, new_note}, 32'd0);
        chk("reset_song_done", {31'd0, song_done}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Latency from play, with note_done already high (stale level).
        push_note(2'd0, 0);
        @(posedge clk); #1 play = 1'b1; note_done = 1'b1;
        check_gap("latency", 1'b0);
        chk("first_note", {26'd0, note}, 32'd20);
        chk("first_duration", {26'd0, duration}, 32'd12);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("stale_level_k%0d", k), {31'd0, new_note}, 32'd0);
        end
        @(posedge clk); #1 note_done = 1'b0;
        push_note(2'd0, 1);
        @(posedge clk); #1 note_done = 1'b1;
        check_gap("stale_rise", 1'b0);

        // idx 2, then the end marker at idx 3 and an automatic restart.
        push_note(2'd0, 2);
        @(posedge clk); #1 note_done = 1'b0;
        @(posedge clk); #1 note_done = 1'b1;
        wait_ev(1'b0, "song0_idx2");
        push_done();
        push_note(2'd0, 0);
        @(posedge clk); #1 note_done = 1'b0;
        @(posedge clk); #1 note_done = 1'b1;
        check_gap("end_marker", 1'b1);
        wait_ev(1'b0, "end_marker_restart");

        // Asynchronous reset mid-song.
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("midreset_note", {26'd0, note}, 32'd0);
        chk("midreset_duration", {26'd0, duration}, 32'd0);
        chk("midreset_new_note", {31'd0, new_note}, 32'd0);
        chk("midreset_song_done", {31'd0, song_done}, 32'd0);
        @(posedge clk); #1 rst = 1'b0; play = 1'b0; note_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("idle_after_reset_k%0d", k), {31'd0, new_note}, 32'd0);
        end

        play_through(2'd0, 1'b0);
        play_through(2'd2, 1'b0);
        play_through(2'd3, 1'b0);
        play_through(2'd1, 1'b1);

        // Song change in WAIT_DONE with a same-cycle done rise, then a stall in FETCH.
        push_note(2'd0, 0);
        @(posedge clk); #1 song = 2'd0;
        wait_ev(1'b0, "chg_song0_idx0");
        push_note(2'd0, 1);
        done_pulse();
        wait_ev(1'b0, "chg_song0_idx1");
        push_note(2'd2, 0);
        @(posedge clk); #1 song = 2'd2; note_done = 1'b1;
        @(posedge clk); #1 play = 1'b0; note_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("fetch_stall_k%0d", k), {31'd0, new_note}, 32'd0);
        end
        @(posedge clk); #1 play = 1'b1;
        wait_ev(1'b0, "chg_song2_idx0");

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
